// File: rtl/fmv_ddr_fetch_scheduler.sv
// fmv_ddr_fetch_scheduler
//   Arbitrates burst reads from the shared DDR host port among the FMV
//   frame-fetch requesters (0=U, 1=V, 2=Y). It owns the read/acquire
//   handshake, counts returned beats and steers each beat to the granted port.
//
//   Optional feature macro: FMV_FETCH_RR_EN
//     defined   -> round-robin arbitration; the search starts at the last
//                  granted index + 1
//     undefined -> strict fixed priority; the lowest index wins
//
// Ports
//   clk, reset           DDR-domain clock; asynchronous active-low reset
//   abort                drop the rest of the current burst (vblank)
//   req_valid/addr/burstcnt   per-port request (flattened, port 0 in the LSBs)
//   req_ready            one-cycle accept pulse to the granted port
//   port_data_valid      per-port beat strobe; rdata carries the beat
//   port_done            one-cycle pulse after the last beat of a burst
//   ddr_*                DDR host port command / response side
//   timeout_err          sticky: no beat arrived within TIMEOUT DATA cycles
module fmv_ddr_fetch_scheduler #(
  parameter int NUM_PORTS = 3,
  parameter int BURST_W   = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         abort,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [NUM_PORTS*29-1:0]      req_addr,
  input  logic [NUM_PORTS*BURST_W-1:0] req_burstcnt,
  output logic [NUM_PORTS-1:0]         req_ready,
  output logic [NUM_PORTS-1:0]         port_data_valid,
  output logic [NUM_PORTS-1:0]         port_done,
  output logic [63:0]                  rdata,
  output logic [28:0]                  ddr_addr,
  output logic [BURST_W-1:0]           ddr_burstcnt,
  output logic                         ddr_read,
  output logic                         ddr_acquire,
  input  logic                         ddr_busy,
  input  logic [63:0]                  ddr_rdata,
  input  logic                         ddr_rdata_ready,
  output logic                         timeout_err
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [BURST_W-1:0]   rem_q, rem_d, rem_dec;
  logic [28:0]          addr_q, addr_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic                 read_q, read_d;
  logic                 acq_q, acq_d;
  logic [NUM_PORTS-1:0] ready_q, ready_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 terr_q, terr_d;

  logic [NUM_PORTS-1:0] cand;
  logic                 found;
  logic [IDX_W-1:0]     win;
  logic [24:0]          sel_addr;
  logic [BURST_W-1:0]   sel_cnt;
  logic [NUM_PORTS-1:0] gnt_onehot;
  logic                 sup;
  logic                 active;
  logic                 unused_addr_bits;

  // Only bits [27:3] of each address reach the DDR port.
  assign unused_addr_bits = ^req_addr;

  // A port whose accept pulse is on the wire still shows its old request;
  // masking it prevents a second grant of the same request.
  assign cand = req_valid & ~ready_q;

`ifdef FMV_FETCH_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = IDX_W'((32'(rr_ptr_q) + k) % NUM_PORTS);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
    end else if (state_q == IDLE && found) begin
      rr_ptr_q <= win;
    end
  end
`else
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end
`endif

  assign sel_addr   = req_addr[win*29 + 3 +: 25];
  assign sel_cnt    = req_burstcnt[win*BURST_W +: BURST_W];
  assign gnt_onehot = NUM_PORTS'(1) << gnt_q;
  assign active     = (state_q == ISSUE) || (state_q == DATA);
  // A beat coinciding with abort is already suppressed.
  assign sup        = aborted_q | abort;
  assign rem_dec    = (ddr_rdata_ready && rem_q != '0) ? rem_q - BURST_W'(1) : rem_q;

  assign port_data_valid = (active && ddr_rdata_ready && !sup) ? gnt_onehot : '0;
  assign rdata           = ddr_rdata;
  assign req_ready       = ready_q;
  assign port_done       = done_q;
  assign ddr_addr        = addr_q;
  assign ddr_burstcnt    = cnt_q;
  assign ddr_read        = read_q;
  assign ddr_acquire     = acq_q;
  assign timeout_err     = terr_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    read_d    = read_q;
    acq_d     = acq_q;
    ready_d   = '0;
    done_d    = '0;
    aborted_d = aborted_q;
    tmo_d     = tmo_q;
    terr_d    = terr_q;
    unique case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        tmo_d     = '0;
        if (found) begin
          gnt_d        = win;
          ready_d[win] = 1'b1;
          if (sel_cnt == '0) begin
            done_d[win] = 1'b1;
          end else begin
            addr_d  = {4'b0011, sel_addr};
            cnt_d   = sel_cnt;
            rem_d   = sel_cnt;
            read_d  = 1'b1;
            acq_d   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        rem_d     = rem_dec;
        aborted_d = sup;
        if (!ddr_busy) begin
          read_d = 1'b0;
          if (rem_dec == '0) begin
            done_d  = sup ? '0 : gnt_onehot;
            acq_d   = 1'b0;
            state_d = RELEASE;
          end else begin
            tmo_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        rem_d     = rem_dec;
        aborted_d = sup;
        if (rem_dec == '0) begin
          done_d  = sup ? '0 : gnt_onehot;
          acq_d   = 1'b0;
          state_d = RELEASE;
        end else if (ddr_rdata_ready) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          acq_d   = 1'b0;
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RELEASE: begin
        aborted_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      read_q    <= 1'b0;
      acq_q     <= 1'b0;
      ready_q   <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
      tmo_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      read_q    <= read_d;
      acq_q     <= acq_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      tmo_q     <= tmo_d;
      terr_q    <= terr_d;
    end
  end

endmodule

// File: doc/fmv_ddr_fetch_scheduler.md
# fmv_ddr_fetch_scheduler

Sequences and arbitrates burst reads from the shared DDR host port among the FMV frame-fetch requesters: chroma U, chroma V and luma Y. Sits in the DDR clock domain between the per-plane line buffers/FIFOs and the DDR interface. Owns the read/acquire handshake, counts returned beats, and routes each beat to the granted requester. Requesters only present address and burst length.

## Interface
Parameters:
- NUM_PORTS, 3, number of requesters; index 0 has highest fixed priority (0=U, 1=V, 2=Y)
- BURST_W, 8, width of burst count
- TIMEOUT, 1023, max cycles without a beat in DATA before forced release

Ports:
- clk  in  1  DDR-domain clock; the single clock of the block
- reset  in  1  asynchronous, active-low reset
- abort  in  1  synchronous; discard the remainder of the current burst (vblank)
- req_valid  in  NUM_PORTS  per-port request, held until req_ready
- req_addr  in  NUM_PORTS×29  per-port byte address, 8-byte aligned
- req_burstcnt  in  NUM_PORTS×BURST_W  per-port beat count, 64 bit per beat
- req_ready  out  NUM_PORTS  one-cycle accept pulse
- port_data_valid  out  NUM_PORTS  beat strobe for the granted port
- port_done  out  NUM_PORTS  one-cycle pulse after the last beat
- rdata  out  64  shared beat data, equal to ddr_rdata
- ddr_addr  out  29  {4'b0011, req_addr[27:3]}
- ddr_burstcnt  out  BURST_W  latched burst count
- ddr_read  out  1  read command
- ddr_acquire  out  1  port ownership
- ddr_busy  in  1  command stall
- ddr_rdata  in  64  read data
- ddr_rdata_ready  in  1  beat valid
- timeout_err  out  1  sticky; cleared only by reset

## Operation
- States: IDLE, ISSUE, DATA, RELEASE.
- IDLE:
  - If any req_valid is set, select a winner g (fixed priority, or round-robin under config).
  - Latch addr and burstcnt. Set ddr_read=1, ddr_acquire=1, req_ready[g]=1 for one cycle. Go to ISSUE.
  - A requester with burstcnt=0 is accepted without a DDR command: req_ready and port_done both pulse, and the state returns to IDLE.
- ISSUE:
  - Hold ddr_read, ddr_addr and ddr_burstcnt while ddr_busy=1.
  - On the first cycle with ddr_busy=0, clear ddr_read and go to DATA.
- ISSUE and DATA:
  - Each ddr_rdata_ready decrements the remaining count.
  - port_data_valid[g] = ddr_rdata_ready && !aborted (combinational).
- DATA:
  - When the last beat arrives, pulse port_done[g] on the next cycle, clear ddr_acquire and go to RELEASE.
  - If TIMEOUT cycles pass without a beat, set timeout_err, clear ddr_acquire, go to RELEASE, and give no port_done.
- RELEASE: one settle cycle, then IDLE; no grant is made in RELEASE.
- abort:
  - Sets an internal aborted flag for the current burst.
  - Beats are still counted to completion so that the DDR stays in sync, but no port_data_valid or port_done is produced.
  - The flag clears on entering IDLE.
  - abort in IDLE has no effect; pending requests are still served.
- Beats arriving in IDLE or RELEASE (stale data after reset) are ignored.
- Widths:
  - The remaining-count register is BURST_W bits; it never wraps below 0.
  - ddr_addr drops req_addr[2:0].

## Timing
- Reset values: ddr_read=0, ddr_acquire=0, ddr_addr=0, ddr_burstcnt=0, req_ready=0, port_done=0, timeout_err=0, state=IDLE, RR pointer=NUM_PORTS-1.
- Reset clears outputs immediately (asynchronous), including mid-burst.
- Request sampled in IDLE at edge T: req_ready and ddr_read are high in cycle T+1.
- Requesters deassert req_valid in the cycle they see req_ready. They are not re-granted until RELEASE has completed.
- Last beat at cycle L: port_done at L+1, ddr_acquire low at L+1. Next grant can appear at the earliest in cycle L+3.
- Simultaneous last beat and abort: the beat is suppressed and no port_done is produced.
- Minimum grant-to-grant spacing: burst length + 3 cycles when ddr_busy=0.

## Configuration
- FMV_FETCH_RR_EN defined:
  - Round-robin arbitration. The search starts at the last granted index + 1, modulo NUM_PORTS.
  - The pointer updates only on a grant.
- FMV_FETCH_RR_EN undefined: strict fixed priority, lowest index wins, no pointer logic.

## Test plan
- Single Y request, addr=0x100, burstcnt=2, no busy:
  - ddr_addr=0x6000020 at T+1
  - two port_data_valid[2] strobes
  - port_done[2] one cycle after the second beat
  - acquire low the same cycle as port_done[2]
- U, V and Y all valid together, fixed priority: grant order is 0, 1, 2, each U/V burst 25 beats. With FMV_FETCH_RR_EN and pointer=0 after a U grant, the next order is V, then Y.
- ddr_busy held for 5 cycles after the grant: ddr_read stays high for all 6 cycles with a stable address; DATA is entered only after busy drops.
- abort on the 10th beat of a 25-beat U burst:
  - port_data_valid[0] stops after beat 9
  - the remaining 16 beats are counted silently
  - no port_done; return to IDLE
- No beats after the grant with TIMEOUT=15: timeout_err=1 after 15 DATA cycles, acquire drops, and a subsequent request is served.
- Reset asserted mid-burst: read and acquire go to 0 immediately. Beats still arriving after reset release produce no port_data_valid.
